bp_me_cache_dma_arbiter: RTL
============================

# bp_me_cache_dma_arbiter

Shares one DRAM-side streaming memory port among `num_slices_p` L2 cache slices. Each slice issues DMA commands as a header plus, for writes, `block_size_in_words_p` dword data beats. The block grants the command channel round-robin, locks the grant for the length of a write burst, and records each issued command's slice id and type in an in-order tag FIFO. DRAM responses are routed back to the originating slice using the head of that FIFO. It sits between the cache slices' DMA ports and the DRAM memory header/data channels.

## Interface
- `num_slices_p`, 2: number of requesting slices (≥2).
- `hdr_width_p`, 64: opaque command/response header width.
- `dword_width_p`, 64: data beat width.
- `block_size_in_words_p`, 8: beats per block (≥2).
- `outstanding_p`, 4: tag FIFO depth, i.e. the maximum number of commands in flight.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `slice_cmd_header_i`  in  num*hdr  per-slice headers, flattened; slice i occupies bits [i*hdr +: hdr].
- `slice_cmd_wr_i`  in  num  1 = write command.
- `slice_cmd_header_v_i`  in  num  header valid.
- `slice_cmd_header_yumi_o`  out  num  header consumed.
- `slice_cmd_data_i`  in  num*dword  write beats.
- `slice_cmd_data_v_i`  in  num  beat valid.
- `slice_cmd_data_yumi_o`  out  num  beat consumed.
- `slice_resp_data_o`  out  dword  read beat, broadcast to all slices.
- `slice_resp_data_v_o`  out  num  per-slice beat valid.
- `slice_resp_data_ready_i`  in  num  per-slice ready.
- `mem_cmd_header_o` / `_v_o` / `_yumi_i`  out/out/in  hdr/1/1  DRAM command header.
- `mem_cmd_data_o` / `_v_o` / `_yumi_i`  out/out/in  dword/1/1  DRAM write data.
- `mem_resp_header_i` / `_v_i` / `_ready_o`  in/in/out  hdr/1/1  DRAM response header; consumed and dropped.
- `mem_resp_data_i` / `_v_i` / `_ready_o`  in/in/out  dword/1/1  DRAM read data.

## Operation
- Command FSM states: `e_cmd_idle`, `e_cmd_data`.
- `e_cmd_idle`:
  - When any header_v is set and the FIFO is not full, select the winner round-robin, starting at `rr_ptr`.
  - Drive the winner's header, with `mem_cmd_header_v_o` = 1.
  - On `mem_cmd_header_yumi_i`: assert the winner's `header_yumi_o`, push {id, wr} into the FIFO, and set `rr_ptr` = id+1 mod num.
  - If the command is a write, latch `grant_id` and go to `e_cmd_data`; otherwise stay in idle.
- `e_cmd_data`:
  - Pass `slice_cmd_data_i[grant_id]` and its valid to `mem_cmd_data_*`, and route `mem_cmd_data_yumi_i` back to the same slice.
  - A beat counter (clog2 of block size bits) counts accepted beats; on the final beat, go to idle.
  - No header grants are issued while in this state.
- Response FSM states: `e_resp_idle`, `e_resp_data`.
- `e_resp_idle`:
  - `mem_resp_header_ready_o` = FIFO not empty.
  - On accepting a header: if the head entry is a write, pop it and stay idle; if a read, go to `e_resp_data`.
- `e_resp_data`:
  - `slice_resp_data_v_o[head.id]` = `mem_resp_data_v_i`; every other slice's valid is 0.
  - `mem_resp_data_ready_o` = `slice_resp_data_ready_i[head.id]`.
  - Count handshakes; on the last beat, pop the FIFO and go to idle.
- FIFO push and pop may occur in the same cycle. A response header arriving while the FIFO is empty is not accepted: ready stays 0, so unsolicited headers stall.
- Data is never accepted in `e_resp_idle`. A data beat arriving in the same cycle as its header waits one cycle.

## Timing
- On reset, all of the following are 0 or empty: both FSMs idle, `rr_ptr`, beat counters, the FIFO, and every `_v_o`, `_yumi_o` and `_ready_o` output.
- Reset asserted mid-burst aborts immediately. Upstream and downstream must also be reset.
- Header path is combinational, 0-cycle: slice header_v → `mem_cmd_header_v_o`, and `mem_cmd_header_yumi_i` → slice yumi in the same cycle.
- Write data and read data are both combinational pass-throughs: 1 beat per cycle at full throughput, with no added latency.
- A new command header is eligible in the cycle after the last write beat, or in the cycle after a read header's yumi.
- The FIFO-full check uses the registered count. A pop in the same cycle does not enable a push.

## Test plan
- Slice 0 reads alone → header forwarded in the same cycle, FIFO count 1. After the DRAM header plus 8 beats (0xA0..0xA7), slice 0 sees exactly those 8 beats, slice 1's valid stays 0, and the FIFO ends empty.
- Both slices assert read headers in the same cycle after reset → slice 0 is granted in cycle 0 and slice 1 in cycle 1. Responses return in order: the first 8 beats go to slice 0, the next 8 to slice 1.
- Slice 1 writes 8 beats while slice 0 holds header_v → slice 0 gets no yumi until the cycle after beat 8. The DRAM sees 8 beats in order, each with valid held high during stalls.
- Issue 4 reads with no responses → the 5th header is not granted. After one full response completes, the 5th is granted in the following cycle.
- Write response header arrives → accepted and popped in one cycle, with no `slice_resp_data_v_o` asserted. A response header arriving with the FIFO empty sees ready held at 0.
- Slice 0 ready is deasserted during read beat 3 → `mem_resp_data_ready_o` = 0 and the beat counter holds. After ready returns, beats 3..7 deliver intact.

Source files
------------

// File: rtl/bp_me_cache_dma_arbiter_if.sv
// Slice-side DMA ports and DRAM-side streaming port shared by the arbiter.
// master = arbiter side, slave = the slices/DRAM environment.
interface bp_me_cache_dma_arbiter_if #(
  parameter int num_slices_p  = 2,
  parameter int hdr_width_p   = 64,
  parameter int dword_width_p = 64
);
  logic [num_slices_p-1:0][hdr_width_p-1:0]   slice_cmd_header_i;
  logic [num_slices_p-1:0]                    slice_cmd_wr_i;
  logic [num_slices_p-1:0]                    slice_cmd_header_v_i;
  logic [num_slices_p-1:0]                    slice_cmd_header_yumi_o;
  logic [num_slices_p-1:0][dword_width_p-1:0] slice_cmd_data_i;
  logic [num_slices_p-1:0]                    slice_cmd_data_v_i;
  logic [num_slices_p-1:0]                    slice_cmd_data_yumi_o;
  logic [dword_width_p-1:0]                   slice_resp_data_o;
  logic [num_slices_p-1:0]                    slice_resp_data_v_o;
  logic [num_slices_p-1:0]                    slice_resp_data_ready_i;

  logic [hdr_width_p-1:0]   mem_cmd_header_o;
  logic                     mem_cmd_header_v_o;
  logic                     mem_cmd_header_yumi_i;
  logic [dword_width_p-1:0] mem_cmd_data_o;
  logic                     mem_cmd_data_v_o;
  logic                     mem_cmd_data_yumi_i;
  logic [hdr_width_p-1:0]   mem_resp_header_i;
  logic                     mem_resp_header_v_i;
  logic                     mem_resp_header_ready_o;
  logic [dword_width_p-1:0] mem_resp_data_i;
  logic                     mem_resp_data_v_i;
  logic                     mem_resp_data_ready_o;

  modport master (
    input  slice_cmd_header_i, slice_cmd_wr_i, slice_cmd_header_v_i,
    output slice_cmd_header_yumi_o,
    input  slice_cmd_data_i, slice_cmd_data_v_i,
    output slice_cmd_data_yumi_o,
    output slice_resp_data_o, slice_resp_data_v_o,
    input  slice_resp_data_ready_i,
    output mem_cmd_header_o, mem_cmd_header_v_o,
    input  mem_cmd_header_yumi_i,
    output mem_cmd_data_o, mem_cmd_data_v_o,
    input  mem_cmd_data_yumi_i,
    input  mem_resp_header_i, mem_resp_header_v_i,
    output mem_resp_header_ready_o,
    input  mem_resp_data_i, mem_resp_data_v_i,
    output mem_resp_data_ready_o
  );

  modport slave (
    output slice_cmd_header_i, slice_cmd_wr_i, slice_cmd_header_v_i,
    input  slice_cmd_header_yumi_o,
    output slice_cmd_data_i, slice_cmd_data_v_i,
    input  slice_cmd_data_yumi_o,
    input  slice_resp_data_o, slice_resp_data_v_o,
    output slice_resp_data_ready_i,
    input  mem_cmd_header_o, mem_cmd_header_v_o,
    output mem_cmd_header_yumi_i,
    input  mem_cmd_data_o, mem_cmd_data_v_o,
    output mem_cmd_data_yumi_i,
    output mem_resp_header_i, mem_resp_header_v_i,
    input  mem_resp_header_ready_o,
    output mem_resp_data_i, mem_resp_data_v_i,
    input  mem_resp_data_ready_o
  );
endinterface

// File: rtl/bp_me_cache_dma_arbiter.sv
// Round-robin arbiter sharing one DRAM streaming port among L2 slices; an
// in-order tag FIFO steers DRAM responses back to the issuing slice.

module bp_me_cache_dma_arbiter_lane #(
  parameter int id_w    = 1,
  parameter int lane_id = 0
) (
  input  logic [id_w-1:0] hdr_win,
  input  logic            hdr_fire,
  input  logic [id_w-1:0] grant_id,
  input  logic            wdata_yumi,
  input  logic [id_w-1:0] head_id,
  input  logic            resp_sel,
  input  logic            resp_data_v,
  output logic            hdr_yumi,
  output logic            data_yumi,
  output logic            resp_v
);
  localparam logic [id_w-1:0] my_id = id_w'(lane_id);

  assign hdr_yumi  = hdr_fire   && (hdr_win  == my_id);
  assign data_yumi = wdata_yumi && (grant_id == my_id);
  assign resp_v    = resp_sel && resp_data_v && (head_id == my_id);
endmodule

module bp_me_cache_dma_arbiter #(
  parameter int num_slices_p          = 2,
  parameter int hdr_width_p           = 64,
  parameter int dword_width_p         = 64,
  parameter int block_size_in_words_p = 8,
  parameter int outstanding_p         = 4
) (
  input logic clk_i,
  input logic reset_i,
  bp_me_cache_dma_arbiter_if.master bus
);
  localparam int id_w   = $clog2(num_slices_p);
  localparam int beat_w = $clog2(block_size_in_words_p);
  localparam int ptr_w  = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w  = $clog2(outstanding_p + 1);

  typedef enum logic { e_cmd_idle, e_cmd_data } cmd_state_e;
  typedef enum logic { e_resp_idle, e_resp_data } resp_state_e;

  typedef struct packed {
    logic [id_w-1:0] id;
    logic            wr;
  } tag_t;

  cmd_state_e  cmd_state;
  resp_state_e resp_state;

  logic [id_w-1:0]   rr_ptr, grant_id, win_id;
  logic [beat_w-1:0] wbeat_cnt, resp_cnt;
  logic              any_v, win_wr;
  logic              cmd_hdr_v, hdr_fire, wdata_fire, wbeat_last;
  logic              resp_hdr_fire, resp_data_fire, resp_last;
  logic              push, pop;

  tag_t              fifo_mem [outstanding_p];
  logic [ptr_w-1:0]  wptr, rptr;
  logic [cnt_w-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;
  tag_t              head;

  logic [num_slices_p-1:0] hdr_yumi, data_yumi, resp_v;

  function automatic logic [id_w-1:0] rr_idx(input logic [id_w-1:0] base, input int k);
    return id_w'((int'(base) + k) % num_slices_p);
  endfunction

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk downward so the last hit (the one closest to rr_ptr) wins.
  always_comb begin
    win_id = '0;
    any_v  = 1'b0;
    for (int k = num_slices_p - 1; k >= 0; k--) begin
      if (bus.slice_cmd_header_v_i[rr_idx(rr_ptr, k)]) begin
        win_id = rr_idx(rr_ptr, k);
        any_v  = 1'b1;
      end
    end
  end

  assign fifo_full  = (fifo_cnt == cnt_w'(outstanding_p));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rptr];

  assign win_wr     = bus.slice_cmd_wr_i[win_id];
  assign cmd_hdr_v  = ~reset_i && (cmd_state == e_cmd_idle) && any_v && ~fifo_full;
  assign hdr_fire   = cmd_hdr_v && bus.mem_cmd_header_yumi_i;
  assign wdata_fire = bus.mem_cmd_data_v_o && bus.mem_cmd_data_yumi_i;
  assign wbeat_last = (wbeat_cnt == beat_w'(block_size_in_words_p - 1));

  assign bus.mem_cmd_header_o   = bus.slice_cmd_header_i[win_id];
  assign bus.mem_cmd_header_v_o = cmd_hdr_v;
  assign bus.mem_cmd_data_o     = bus.slice_cmd_data_i[grant_id];
  assign bus.mem_cmd_data_v_o   = (cmd_state == e_cmd_data) && bus.slice_cmd_data_v_i[grant_id];

  assign bus.mem_resp_header_ready_o = (resp_state == e_resp_idle) && ~fifo_empty;
  assign bus.mem_resp_data_ready_o   = (resp_state == e_resp_data) && bus.slice_resp_data_ready_i[head.id];
  assign bus.slice_resp_data_o       = bus.mem_resp_data_i;

  assign resp_hdr_fire  = bus.mem_resp_header_ready_o && bus.mem_resp_header_v_i;
  assign resp_data_fire = bus.mem_resp_data_ready_o && bus.mem_resp_data_v_i;
  assign resp_last      = (resp_cnt == beat_w'(block_size_in_words_p - 1));

  // Write responses carry no data, so their tag retires with the header.
  assign push = hdr_fire;
  assign pop  = (resp_hdr_fire && head.wr) || (resp_data_fire && resp_last);

  for (genvar i = 0; i < num_slices_p; i++) begin : g_lane
    bp_me_cache_dma_arbiter_lane #(.id_w(id_w), .lane_id(i)) u_lane (
      .hdr_win     (win_id),
      .hdr_fire    (hdr_fire),
      .grant_id    (grant_id),
      .wdata_yumi  (wdata_fire),
      .head_id     (head.id),
      .resp_sel    (resp_state == e_resp_data),
      .resp_data_v (bus.mem_resp_data_v_i),
      .hdr_yumi    (hdr_yumi[i]),
      .data_yumi   (data_yumi[i]),
      .resp_v      (resp_v[i])
    );
  end

  assign bus.slice_cmd_header_yumi_o = hdr_yumi;
  assign bus.slice_cmd_data_yumi_o   = data_yumi;
  assign bus.slice_resp_data_v_o     = resp_v;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_state <= e_cmd_idle;
      rr_ptr    <= '0;
      grant_id  <= '0;
      wbeat_cnt <= '0;
    end else begin
      case (cmd_state)
        e_cmd_idle: if (hdr_fire) begin
          rr_ptr <= (win_id == id_w'(num_slices_p - 1)) ? '0 : win_id + 1'b1;
          if (win_wr) begin
            grant_id  <= win_id;
            wbeat_cnt <= '0;
            cmd_state <= e_cmd_data;
          end
        end
        e_cmd_data: if (wdata_fire) begin
          if (wbeat_last) begin
            wbeat_cnt <= '0;
            cmd_state <= e_cmd_idle;
          end else begin
            wbeat_cnt <= wbeat_cnt + 1'b1;
          end
        end
        default: cmd_state <= e_cmd_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_state <= e_resp_idle;
      resp_cnt   <= '0;
    end else begin
      case (resp_state)
        e_resp_idle: if (resp_hdr_fire && !head.wr) begin
          resp_cnt   <= '0;
          resp_state <= e_resp_data;
        end
        e_resp_data: if (resp_data_fire) begin
          if (resp_last) begin
            resp_cnt   <= '0;
            resp_state <= e_resp_idle;
          end else begin
            resp_cnt <= resp_cnt + 1'b1;
          end
        end
        default: resp_state <= e_resp_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= '{id: win_id, wr: win_wr};
  end
endmodule
